// File: rtl/ofs_plat_prim_uid_retire.sv
// UID retire: keeps per-UID request metadata, forwards tagged response
// beats with it, and frees the UID to the allocator on the last beat.
module ofs_plat_prim_uid_retire #(
  parameter int N_ENTRIES   = 32,
  parameter int N_RESERVED  = 0,
  parameter int N_META_BITS = 16,
  parameter int N_DATA_BITS = 64,
  localparam int UW = $clog2(N_ENTRIES),
  localparam int CW = $clog2(N_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   req_en,
  input  logic [UW-1:0]          req_uid,
  input  logic [N_META_BITS-1:0] req_meta,

  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [UW-1:0]          rsp_uid,
  input  logic                   rsp_last,
  input  logic [N_DATA_BITS-1:0] rsp_data,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [UW-1:0]          out_uid,
  output logic [N_META_BITS-1:0] out_meta,
  output logic [N_DATA_BITS-1:0] out_data,
  output logic                   out_last,

  output logic                   free,
  output logic [UW-1:0]          free_uid,
  output logic [CW-1:0]          num_outstanding,
  output logic                   err_alloc,
  output logic                   err_rsp
);

  logic [N_ENTRIES-1:0]   busy;
  logic [N_ENTRIES-1:0]   busy_nxt;
  logic [N_ENTRIES-1:0]   uid_ok;
  logic [N_META_BITS-1:0] meta_mem [N_ENTRIES];

  logic rsp_fire;
  logic rsp_legal;
  logic retire;
  logic req_ok;
  logic req_bad;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_ok
    assign uid_ok[i] = (i >= N_RESERVED);
  end

  assign rsp_ready = !out_valid || out_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_legal = busy[rsp_uid] && uid_ok[rsp_uid];
  assign retire    = rsp_fire && rsp_legal && rsp_last;

  assign req_ok  = req_en && !busy[req_uid] && uid_ok[req_uid];
  assign req_bad = req_en && !req_ok;

  // A legal request and a retire never target the same UID.
  always_comb begin
    busy_nxt = busy;
    if (retire) busy_nxt[rsp_uid] = 1'b0;
    if (req_ok) busy_nxt[req_uid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy            <= '0;
      out_valid       <= 1'b0;
      free            <= 1'b0;
      num_outstanding <= '0;
      err_alloc       <= 1'b0;
      err_rsp         <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (rsp_ready) out_valid <= rsp_valid;
      free <= retire;
      if (req_ok && !retire)
        num_outstanding <= num_outstanding + CW'(1);
      else if (retire && !req_ok)
        num_outstanding <= num_outstanding - CW'(1);
      if (req_bad) err_alloc <= 1'b1;
      if (rsp_fire && !rsp_legal) err_rsp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      out_uid  <= rsp_uid;
      out_meta <= rsp_legal ? meta_mem[rsp_uid] : '0;
      out_data <= rsp_data;
      out_last <= rsp_last;
    end
    free_uid <= rsp_uid;
    if (req_ok) meta_mem[req_uid] <= req_meta;
  end

endmodule

// File: tb/tb_ofs_plat_prim_uid_retire.sv
// Bench for ofs_plat_prim_uid_retire: vector table plus a beat
// scoreboard and hand sequences for stalls, reserved UIDs and reset.
module tb_ofs_plat_prim_uid_retire;

  typedef struct {
    logic [4:0]  uid;
    logic [15:0] meta;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        req_en;
    logic [4:0]  req_uid;
    logic [15:0] req_meta;
    logic        rsp_valid;
    logic [4:0]  rsp_uid;
    logic        rsp_last;
    logic [63:0] rsp_data;
    int          exp_cnt;
  } vec_t;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        req_en = 0;
  logic [4:0]  req_uid = 0;
  logic [15:0] req_meta = 0;
  logic        rsp_valid = 0;
  logic [4:0]  rsp_uid = 0;
  logic        rsp_last = 0;
  logic [63:0] rsp_data = 0;
  logic        out_ready = 1;
  logic        rsp_ready, out_valid, out_last, free;
  logic [4:0]  out_uid, free_uid;
  logic [15:0] out_meta;
  logic [63:0] out_data;
  logic [5:0]  num_outstanding;
  logic        err_alloc, err_rsp;

  logic        r_req_en = 0;
  logic [4:0]  r_req_uid = 0;
  logic        r_rsp_valid = 0;
  logic [4:0]  r_rsp_uid = 0;
  logic        r_rsp_ready, r_out_valid, r_out_last, r_free;
  logic [4:0]  r_out_uid, r_free_uid;
  logic [15:0] r_out_meta;
  logic [63:0] r_out_data;
  logic [5:0]  r_cnt;
  logic        r_err_alloc, r_err_rsp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ofs_plat_prim_uid_retire dut (
    .clk(clk), .reset_n(reset_n),
    .req_en(req_en), .req_uid(req_uid), .req_meta(req_meta),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uid(rsp_uid),
    .rsp_last(rsp_last), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_uid(out_uid),
    .out_meta(out_meta), .out_data(out_data), .out_last(out_last),
    .free(free), .free_uid(free_uid),
    .num_outstanding(num_outstanding),
    .err_alloc(err_alloc), .err_rsp(err_rsp)
  );

  ofs_plat_prim_uid_retire #(.N_RESERVED(2)) u_res (
    .clk(clk), .reset_n(reset_n),
    .req_en(r_req_en), .req_uid(r_req_uid), .req_meta(16'h1357),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_uid(r_rsp_uid),
    .rsp_last(1'b1), .rsp_data(64'h77),
    .out_valid(r_out_valid), .out_ready(1'b1), .out_uid(r_out_uid),
    .out_meta(r_out_meta), .out_data(r_out_data), .out_last(r_out_last),
    .free(r_free), .free_uid(r_free_uid),
    .num_outstanding(r_cnt),
    .err_alloc(r_err_alloc), .err_rsp(r_err_rsp)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard model of the main DUT, stepped on the falling edge.
  beat_t       q[$];
  logic        mon_on = 0;
  logic [31:0] m_busy = 0;
  logic [15:0] m_meta [32];
  logic        m_ov = 0, m_free = 0, m_ea = 0, m_er = 0;
  logic [4:0]  m_free_uid = 0;
  int          m_cnt = 0;

  always @(negedge clk) begin
    beat_t b;
    logic  acc, leg, rok;
    if (mon_on) begin
      chk("rsp_ready", rsp_ready, !m_ov || out_ready);
      chk("out_valid", out_valid, m_ov);
      chk("free", free, m_free);
      if (m_free) chk("free_uid", free_uid, m_free_uid);
      chk("num_outstanding", num_outstanding, m_cnt);
      chk("err_alloc", err_alloc, m_ea);
      chk("err_rsp", err_rsp, m_er);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_beat", 1, 0);
        end else begin
          b = q.pop_front();
          chk("out_uid", out_uid, b.uid);
          chk("out_meta", out_meta, b.meta);
          chk("out_data", out_data, b.data);
          chk("out_last", out_last, b.last);
        end
      end
      if (!reset_n) begin
        m_busy = 0; m_ov = 0; m_free = 0; m_cnt = 0;
        m_ea = 0; m_er = 0; q.delete();
      end else begin
        acc = rsp_valid && (!m_ov || out_ready);
        leg = m_busy[rsp_uid];
        rok = req_en && !m_busy[req_uid];
        if (acc) begin
          b.uid = rsp_uid; b.data = rsp_data; b.last = rsp_last;
          b.meta = leg ? m_meta[rsp_uid] : 16'h0;
          q.push_back(b);
        end
        if (!m_ov || out_ready) m_ov = rsp_valid;
        m_free = acc && leg && rsp_last;
        m_free_uid = rsp_uid;
        if (acc && !leg) m_er = 1;
        if (req_en && !rok) m_ea = 1;
        if (m_free) begin m_busy[rsp_uid] = 0; m_cnt--; end
        if (rok) begin
          m_busy[req_uid] = 1; m_meta[req_uid] = req_meta; m_cnt++;
        end
      end
    end
  end

  function automatic vec_t v(input logic re, input logic [4:0] ru,
                             input logic [15:0] rm, input logic sv,
                             input logic [4:0] su, input logic sl,
                             input logic [63:0] sd, input int c);
    vec_t t;
    t.req_en = re; t.req_uid = ru; t.req_meta = rm;
    t.rsp_valid = sv; t.rsp_uid = su; t.rsp_last = sl;
    t.rsp_data = sd; t.exp_cnt = c;
    return t;
  endfunction

  task automatic idle();
    req_en = 0; rsp_valid = 0; rsp_last = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt.push_back(v(1, 3, 16'h00AA, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 1, 3, 1, 64'h1234, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 1, 16'h0101, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 2, 16'h0202, 0, 0, 0, 0, 2));
    vt.push_back(v(1, 5, 16'h0505, 0, 0, 0, 0, 3));
    vt.push_back(v(0, 0, 0, 1, 5, 1, 64'h5555, 2));
    vt.push_back(v(0, 0, 0, 1, 1, 1, 64'h1111, 1));
    vt.push_back(v(0, 0, 0, 1, 2, 1, 64'h2222, 0));
    vt.push_back(v(1, 9, 16'h0909, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 6, 16'h0606, 1, 9, 1, 64'h9999, 1));
    vt.push_back(v(0, 0, 0, 1, 6, 1, 64'h6666, 0));
    vt.push_back(v(0, 0, 0, 1, 7, 1, 64'h7777, 0));
    vt.push_back(v(1, 8, 16'h0808, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 8, 16'h8888, 1, 8, 1, 64'h8888, 0));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));

    cyc(); cyc();
    mon_on = 1;
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", num_outstanding, 0);
    reset_n = 1;

    for (int i = 0; i < vt.size(); i++) begin
      cyc();
      if (i > 0) chk("tbl_cnt", num_outstanding, vt[i-1].exp_cnt);
      req_en = vt[i].req_en; req_uid = vt[i].req_uid;
      req_meta = vt[i].req_meta; rsp_valid = vt[i].rsp_valid;
      rsp_uid = vt[i].rsp_uid; rsp_last = vt[i].rsp_last;
      rsp_data = vt[i].rsp_data;
    end
    cyc();
    chk("tbl_cnt_end", num_outstanding, vt[vt.size()-1].exp_cnt);
    idle();
    chk("err_rsp_sticky", err_rsp, 1);
    chk("err_alloc_same_uid", err_alloc, 1);

    // Two-beat response held off by the consumer.
    req_en = 1; req_uid = 4; req_meta = 16'h0404;
    cyc();
    idle();
    rsp_valid = 1; rsp_uid = 4; rsp_last = 0; rsp_data = 64'hA0;
    out_ready = 0;
    cyc();
    rsp_last = 1; rsp_data = 64'hA1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rsp_ready", rsp_ready, 0);
      chk("stall_out_data", out_data, 64'hA0);
      chk("stall_free", free, 0);
      cyc();
    end
    out_ready = 1;
    cyc();
    idle();
    chk("bp_out_data", out_data, 64'hA1);
    chk("bp_out_last", out_last, 1);
    chk("bp_free", free, 1);
    chk("bp_free_uid", free_uid, 4);
    cyc();
    chk("bp_free_once", free, 0);

    // Reserved UIDs on the N_RESERVED=2 instance.
    r_req_en = 1; r_req_uid = 1;
    cyc();
    r_req_en = 0;
    r_rsp_valid = 1; r_rsp_uid = 0;
    chk("res_err_alloc", r_err_alloc, 1);
    chk("res_cnt", r_cnt, 0);
    cyc();
    r_rsp_valid = 0;
    chk("res_out_valid", r_out_valid, 1);
    chk("res_out_meta", r_out_meta, 0);
    chk("res_err_rsp", r_err_rsp, 1);
    chk("res_no_free", r_free, 0);

    // Reset with four UIDs outstanding and a held beat.
    for (int k = 10; k < 14; k++) begin
      req_en = 1; req_uid = 5'(k); req_meta = 16'(k);
      cyc();
    end
    idle();
    out_ready = 0;
    rsp_valid = 1; rsp_uid = 10; rsp_last = 0; rsp_data = 64'hBB;
    cyc();
    idle();
    cyc();
    chk("pre_rst_cnt", num_outstanding, 4);
    chk("pre_rst_out_valid", out_valid, 1);
    reset_n = 0;
    cyc();
    reset_n = 1;
    out_ready = 1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt", num_outstanding, 0);
    chk("mid_rst_err_alloc", err_alloc, 0);
    chk("mid_rst_err_rsp", err_rsp, 0);
    chk("mid_rst_free", free, 0);
    cyc(); cyc();
    chk("post_rst_free", free, 0);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
